// File: rtl/seq_pkg.sv
// Shared sequence definitions: ROM contents used by both generator and checker,
// plus the checker FSM state encoding.
package seq_pkg;

  localparam int SEQ_W   = 8;
  localparam int SEQ_LEN = 8;
  localparam int IDX_W   = $clog2(SEQ_LEN);

  // Element 0 is the least significant word, so ROM[0] = 8'h01.
  localparam logic [SEQ_LEN-1:0][SEQ_W-1:0] SEQ_ROM = {
    8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_SYNC   = 2'd2,
    ST_LOCKED = 2'd3
  } seq_state_e;

  function automatic logic [SEQ_W-1:0] seq_word(input logic [IDX_W-1:0] idx);
    return SEQ_ROM[idx];
  endfunction

endpackage

// File: rtl/seq_err_counter.sv
// Saturating error counter with synchronous clear; clear has priority over increment.
module seq_err_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;
  logic             w_sat;

  assign w_sat   = &r_count;
  assign o_count = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !w_sat) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sequence_checker.sv
// Receive-side sequence checker: hunts for ROM[0], confirms lock over several
// in-order matches, then flags mismatches, counts errors and marks completed passes.
module sequence_checker
  import seq_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int SEQ_LEN       = 8,
  parameter int LOCK_MATCHES  = 3,
  parameter int UNLOCK_MISSES = 2,
  parameter int CNT_W         = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_clr_cnt,
  output logic              o_locked,
  output logic              o_err_pulse,
  output logic              o_seq_done,
  output logic [CNT_W-1:0]  o_err_count,
  output logic [1:0]        o_state
);

  localparam int IW = $clog2(SEQ_LEN);
  localparam int MW = $clog2(LOCK_MATCHES + 1);
  localparam int UW = $clog2(UNLOCK_MISSES + 1);

  seq_state_e       r_state, w_state_n;
  logic [IW-1:0]    r_idx, w_idx_n;
  logic [MW-1:0]    r_match, w_match_n, w_match_inc;
  logic [UW-1:0]    r_miss, w_miss_n, w_miss_inc;
  logic             r_err_pulse, w_err_n;
  logic             r_seq_done, w_done_n;

  logic             w_sample;
  logic             w_hit;
  logic             w_first;
  logic [IW-1:0]    w_idx_inc;

  assign w_sample    = i_enable && i_valid;
  assign w_hit       = (i_data == seq_word(r_idx));
  assign w_first     = (i_data == seq_word('0));
  assign w_idx_inc   = r_idx + IW'(1);
  assign w_match_inc = r_match + MW'(1);
  assign w_miss_inc  = r_miss + UW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_match     <= '0;
      r_miss      <= '0;
      r_err_pulse <= 1'b0;
      r_seq_done  <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_idx       <= w_idx_n;
      r_match     <= w_match_n;
      r_miss      <= w_miss_n;
      r_err_pulse <= w_err_n;
      r_seq_done  <= w_done_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_match_n = r_match;
    w_miss_n  = r_miss;
    w_err_n   = 1'b0;
    w_done_n  = 1'b0;

    if (!i_enable) begin
      w_state_n = ST_IDLE;
      w_idx_n   = '0;
      w_match_n = '0;
      w_miss_n  = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_n = ST_HUNT;
          w_idx_n   = '0;
          w_match_n = '0;
          w_miss_n  = '0;
        end

        ST_HUNT: begin
          if (w_sample && w_first) begin
            w_idx_n   = IW'(1);
            w_match_n = MW'(1);
            w_miss_n  = '0;
            w_state_n = (LOCK_MATCHES == 1) ? ST_LOCKED : ST_SYNC;
          end
        end

        ST_SYNC: begin
          if (w_sample) begin
            if (w_hit) begin
              w_idx_n   = w_idx_inc;
              w_match_n = w_match_inc;
              if (w_match_inc == MW'(LOCK_MATCHES)) begin
                w_state_n = ST_LOCKED;
                w_miss_n  = '0;
              end
            end else if (w_first) begin
              // A fresh start word restarts acquisition rather than losing it.
              w_idx_n   = IW'(1);
              w_match_n = MW'(1);
            end else begin
              w_state_n = ST_HUNT;
              w_idx_n   = '0;
              w_match_n = '0;
            end
          end
        end

        ST_LOCKED: begin
          if (w_sample) begin
            w_idx_n = w_idx_inc;
            if (w_hit) begin
              w_miss_n = '0;
              w_done_n = (r_idx == IW'(SEQ_LEN - 1));
            end else begin
              // Flywheel: keep advancing idx so isolated errors don't desync.
              w_err_n  = 1'b1;
              w_miss_n = w_miss_inc;
              if (w_miss_inc == UW'(UNLOCK_MISSES)) begin
                w_state_n = ST_HUNT;
                w_idx_n   = '0;
                w_match_n = '0;
                w_miss_n  = '0;
              end
            end
          end
        end

        default: begin
          w_state_n = ST_IDLE;
          w_idx_n   = '0;
          w_match_n = '0;
          w_miss_n  = '0;
        end
      endcase
    end
  end

  seq_err_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_clr_cnt),
    .i_inc   (w_err_n),
    .o_count (o_err_count)
  );

  assign o_locked    = (r_state == ST_LOCKED);
  assign o_err_pulse = r_err_pulse;
  assign o_seq_done  = r_seq_done;
  assign o_state     = r_state;

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker; a narrow error counter keeps saturation reachable.
module tb_sequence_checker;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable, valid, clr_cnt;
  logic [7:0]    data;
  logic          locked, err_pulse, seq_done;
  logic [CW-1:0] err_count;
  logic [1:0]    state;

  int n_chk = 0;
  int n_err = 0;
  int e_idx;
  int done_cnt;
  logic [7:0] rom [8];

  always #5 clk = ~clk;

  sequence_checker #(.CNT_W(CW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_enable    (enable),
    .i_valid     (valid),
    .i_data      (data),
    .i_clr_cnt   (clr_cnt),
    .o_locked    (locked),
    .o_err_pulse (err_pulse),
    .o_seq_done  (seq_done),
    .o_err_count (err_count),
    .o_state     (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; return 1 time unit after the capturing edge.
  task automatic step(input logic v, input logic [7:0] d);
    valid = v;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rom[0] = 8'h01; rom[1] = 8'h02; rom[2] = 8'h04; rom[3] = 8'h08;
    rom[4] = 8'h10; rom[5] = 8'h20; rom[6] = 8'h40; rom[7] = 8'h80;
    rst_n = 1'b0; enable = 1'b0; valid = 1'b0; clr_cnt = 1'b0; data = 8'h00;
    #23;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    chk("rst_pulses", {30'd0, err_pulse, seq_done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. acquire lock on 01,02,04
    enable = 1'b1;
    step(1'b0, 8'h00);
    chk("t1_hunt", 32'(state), 32'd1);
    step(1'b1, 8'h01);
    chk("t1_sync_a", 32'(state), 32'd2);
    step(1'b1, 8'h02);
    chk("t1_sync_b", 32'(state), 32'd2);
    step(1'b1, 8'h04);
    chk("t1_locked", 32'(locked), 32'd1);
    chk("t1_state", 32'(state), 32'd3);
    chk("t1_errcnt", 32'(err_count), 32'd0);

    // 2. four full passes from idx 3; done fires after each 80
    done_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      step(1'b1, rom[(3 + k) % 8]);
      chk("t2_done", 32'(seq_done), ((k % 8) == 4) ? 32'd1 : 32'd0);
      if (seq_done) done_cnt++;
    end
    chk("t2_done_cnt", 32'(done_cnt), 32'd4);
    chk("t2_errcnt", 32'(err_count), 32'd0);
    chk("t2_locked", 32'(locked), 32'd1);

    // 3. errors while locked; idx 3 now
    step(1'b1, 8'h08);
    step(1'b1, 8'h55);
    chk("t3_pulse1", 32'(err_pulse), 32'd1);
    chk("t3_cnt1", 32'(err_count), 32'd1);
    chk("t3_lock1", 32'(locked), 32'd1);
    step(1'b1, 8'h20);
    chk("t3_nopulse", 32'(err_pulse), 32'd0);
    chk("t3_lock2", 32'(locked), 32'd1);
    step(1'b1, 8'h55);
    chk("t3_cnt2", 32'(err_count), 32'd2);
    step(1'b1, 8'h55);
    chk("t3_pulse3", 32'(err_pulse), 32'd1);
    chk("t3_cnt3", 32'(err_count), 32'd3);
    chk("t3_unlock", 32'(locked), 32'd0);
    chk("t3_hunt", 32'(state), 32'd1);

    // 4. restart inside SYNC
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    step(1'b1, 8'h01);
    chk("t4_sync", 32'(state), 32'd2);
    chk("t4_nopulse", 32'(err_pulse), 32'd0);
    step(1'b1, 8'h02);
    chk("t4_sync2", 32'(state), 32'd2);
    step(1'b1, 8'h04);
    chk("t4_locked", 32'(locked), 32'd1);
    chk("t4_errcnt", 32'(err_count), 32'd3);

    // 5. gapped valid over a full pass from idx 3
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 8'hFF);
      chk("t5_gap_pulses", {30'd0, err_pulse, seq_done}, 32'd0);
      chk("t5_gap_lock", 32'(locked), 32'd1);
      step(1'b1, rom[(3 + k) % 8]);
      chk("t5_done", 32'(seq_done), (k == 4) ? 32'd1 : 32'd0);
      chk("t5_nopulse", 32'(err_pulse), 32'd0);
    end
    step(1'b1, 8'h08);
    enable = 1'b0;
    step(1'b1, 8'h55);
    chk("t5_idle", 32'(state), 32'd0);
    chk("t5_idle_lock", 32'(locked), 32'd0);
    chk("t5_idle_cnt", 32'(err_count), 32'd3);
    chk("t5_idle_pulse", 32'(err_pulse), 32'd0);
    enable = 1'b1;
    step(1'b0, 8'h00);
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    step(1'b1, 8'h04);
    chk("t5_relock", 32'(locked), 32'd1);

    // 6. saturate at all-ones: 12 more errors, each followed by a good word
    e_idx = 3;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 8'h55);
      e_idx = (e_idx + 1) % 8;
      step(1'b1, rom[e_idx]);
      e_idx = (e_idx + 1) % 8;
    end
    chk("t6_full", 32'(err_count), 32'd15);
    step(1'b1, 8'h55);
    e_idx = (e_idx + 1) % 8;
    chk("t6_sat", 32'(err_count), 32'd15);
    chk("t6_sat_pulse", 32'(err_pulse), 32'd1);
    step(1'b1, rom[e_idx]);
    e_idx = (e_idx + 1) % 8;
    clr_cnt = 1'b1;
    step(1'b1, 8'h55);
    e_idx = (e_idx + 1) % 8;
    clr_cnt = 1'b0;
    chk("t6_clr_wins", 32'(err_count), 32'd0);
    chk("t6_clr_pulse", 32'(err_pulse), 32'd1);
    chk("t6_clr_lock", 32'(locked), 32'd1);
    step(1'b1, rom[e_idx]);
    e_idx = (e_idx + 1) % 8;
    step(1'b1, 8'h55);
    chk("t6_recount", 32'(err_count), 32'd1);
    chk("t6_pre_rst", 32'(err_pulse), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_state", 32'(state), 32'd0);
    chk("t6_rst_lock", 32'(locked), 32'd0);
    chk("t6_rst_cnt", 32'(err_count), 32'd0);
    chk("t6_rst_pulses", {30'd0, err_pulse, seq_done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
